// File: rtl/demux_pkg.sv
// Shared constants and slot state type for the 1-to-8 stream demultiplexer.
package demux_pkg;

    localparam int unsigned DEMUX_WAYS = 8;
    localparam int unsigned SEL_W      = 3;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot: loads on load_i, empties on drain_i unless a load lands the same cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [N-1:0] load_data_i,
    input  logic         drain_i,
    output logic         valid_o,
    output logic [N-1:0] data_o
);

    slot_state_t  state_q;
    logic [N-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            if (load_i) begin
                data_q <= load_data_i;
            end
            unique case (state_q)
                SLOT_EMPTY: if (load_i) state_q <= SLOT_FULL;
                SLOT_FULL:  if (drain_i && !load_i) state_q <= SLOT_EMPTY;
                default:    state_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/demux8_stream.sv
// Registered 1-to-8 valid/ready demultiplexer with per-destination holding slots and a
// saturating stall counter. Define DEMUX8_BROADCAST_EN to add the in_bcast broadcast input.
module demux8_stream
    import demux_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned STALL_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_data,
    input  logic [SEL_W-1:0]        in_sel,
`ifdef DEMUX8_BROADCAST_EN
    input  logic                    in_bcast,
`endif
    output logic [DEMUX_WAYS-1:0]   out_valid,
    input  logic [DEMUX_WAYS-1:0]   out_ready,
    output logic [DEMUX_WAYS*N-1:0] out_data,
    output logic [STALL_W-1:0]      stall_count
);

    logic [DEMUX_WAYS-1:0] slot_ready;
    logic [DEMUX_WAYS-1:0] target;
    logic [DEMUX_WAYS-1:0] load;
    logic [STALL_W-1:0]    stall_d, stall_q;

    // A slot can take a beat if it is empty or is being drained this very cycle.
    assign slot_ready = ~out_valid | out_ready;

    always_comb begin
        target         = '0;
        target[in_sel] = 1'b1;
        in_ready       = slot_ready[in_sel];
`ifdef DEMUX8_BROADCAST_EN
        if (in_bcast) begin
            target   = '1;
            in_ready = &slot_ready;
        end
`endif
    end

    assign load = target & {DEMUX_WAYS{in_valid & in_ready}};

    for (genvar i = 0; i < DEMUX_WAYS; i++) begin : g_slot
        demux_slot #(
            .N (N)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .load_i      (load[i]),
            .load_data_i (in_data),
            .drain_i     (out_ready[i]),
            .valid_o     (out_valid[i]),
            .data_o      (out_data[i*N +: N])
        );
    end

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_demux8_stream.sv
// Self-checking bench for demux8_stream: directed scenarios plus randomized traffic against an
// array-based model of eight holding slots. Honours DEMUX8_BROADCAST_EN when defined.
module tb_demux8_stream;

    localparam int N = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic [N-1:0]   in_data = '0;
    logic [2:0]     in_sel = '0;
    logic           in_bcast = 1'b0;
    logic [7:0]     out_ready = '0;
    logic           in_ready, s_in_ready;
    logic [7:0]     out_valid, s_out_valid;
    logic [8*N-1:0] out_data, s_out_data;
    logic [15:0]    stall_count;
    logic [3:0]     s_stall_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    demux8_stream #(.N(N), .STALL_W(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sel      (in_sel),
`ifdef DEMUX8_BROADCAST_EN
        .in_bcast    (in_bcast),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stall_count (stall_count)
    );

    // Narrow-counter instance fed the same traffic, used to observe saturation.
    demux8_stream #(.N(N), .STALL_W(4)) u_small (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .in_data     (in_data),
        .in_sel      (in_sel),
`ifdef DEMUX8_BROADCAST_EN
        .in_bcast    (in_bcast),
`endif
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .out_data    (s_out_data),
        .stall_count (s_stall_count)
    );

    // Behavioural model: per-slot full flag and payload, plus plain integer stall count.
    bit          m_full [8];
    logic [N-1:0] m_data [8];
    int          m_stall;
    bit          prev_stall;
    logic [N-1:0] prev_data;
    logic [2:0]  prev_sel;

    function automatic bit is_bcast();
`ifdef DEMUX8_BROADCAST_EN
        return in_bcast;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        bit r;
        if (is_bcast()) begin
            r = 1'b1;
            for (int i = 0; i < 8; i++) if (m_full[i] && !out_ready[i]) r = 1'b0;
        end else begin
            r = !m_full[in_sel] || out_ready[in_sel];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_full[i] = 1'b0;
                m_data[i] = '0;
            end
            m_stall    = 0;
            prev_stall = 1'b0;
        end else begin
            bit acc;
            if (prev_stall) begin
                check("handshake_hold", {in_valid, in_sel, in_data}, {1'b1, prev_sel, prev_data});
            end
            acc = in_valid && model_ready();
            prev_stall = in_valid && !acc;
            prev_data  = in_data;
            prev_sel   = in_sel;
            if (prev_stall) m_stall++;
            for (int i = 0; i < 8; i++) begin
                if (out_ready[i]) m_full[i] = 1'b0;
                if (acc && (is_bcast() || in_sel == 3'(i))) begin
                    m_full[i] = 1'b1;
                    m_data[i] = in_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [7:0] ev;
            for (int i = 0; i < 8; i++) begin
                ev[i] = m_full[i];
                check($sformatf("out_data[%0d]", i), 64'(out_data[i*N +: N]), 64'(m_data[i]));
            end
            check("out_valid", 64'(out_valid), 64'(ev));
            check("in_ready", 64'(in_ready), 64'(model_ready()));
            check("stall_count", 64'(stall_count), 64'((m_stall > 65535) ? 65535 : m_stall));
            check("small_stall_count", 64'(s_stall_count), 64'((m_stall > 15) ? 15 : m_stall));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_stall", 64'(stall_count), 64'h0);
        #20 rst = 1'b0;
        step();

        // Single route to slot 3.
        in_valid = 1'b1; in_sel = 3'd3; in_data = 32'hDEADBEEF; out_ready = 8'h00;
        #1 check("route_in_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        check("route_out_valid", 64'(out_valid), 64'h08);
        check("route_out_data3", 64'(out_data[3*N +: N]), 64'hDEADBEEF);
        check("route_out_data_other", 64'(out_data[2*N +: N]), 64'h0);

        // Backpressure on slot 3 for five edges, then same-cycle drain and reload.
        in_valid = 1'b1; in_sel = 3'd3; in_data = 32'hCAFEF00D;
        for (int k = 0; k < 5; k++) begin
            #1 check("bp_in_ready", 64'(in_ready), 64'h0);
            step();
        end
        check("bp_stall_count", 64'(stall_count), 64'd5);
        out_ready = 8'h08;
        #1 check("bp_release_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0; out_ready = 8'h00;
        check("bp_reload_valid", 64'(out_valid), 64'h08);
        check("bp_reload_data", 64'(out_data[3*N +: N]), 64'hCAFEF00D);

        // Fill slot 0, stall it, and stream to slots 1..3 at one beat per cycle.
        out_ready = 8'h08;
        in_valid = 1'b1; in_sel = 3'd0; in_data = 32'h00000A00;
        step();
        out_ready = 8'hFE;
        for (int k = 1; k <= 3; k++) begin
            in_sel = 3'(k); in_data = 32'h100 * k;
            #1 check("indep_in_ready", 64'(in_ready), 64'h1);
            step();
        end
        in_valid = 1'b0;
        step();
        check("indep_out_valid", 64'(out_valid), 64'h01);
        check("indep_stall", 64'(stall_count), 64'd5);

        // Twenty-cycle stall on slot 0 saturates the 4-bit counter.
        in_valid = 1'b1; in_sel = 3'd0; in_data = 32'h55;
        repeat (20) step();
        check("sat_small", 64'(s_stall_count), 64'hF);
        check("sat_wide", 64'(stall_count), 64'd25);
        out_ready = 8'hFF;
        step();
        in_valid = 1'b0;
        step();

`ifdef DEMUX8_BROADCAST_EN
        out_ready = 8'h00;
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 32'h12345678;
        step();
        in_valid = 1'b0;
        check("bcast_valid", 64'(out_valid), 64'hFF);
        check("bcast_data7", 64'(out_data[7*N +: N]), 64'h12345678);
        out_ready = 8'hBF;
        in_valid = 1'b1; in_data = 32'h9ABCDEF0;
        #1 check("bcast_blocked", 64'(in_ready), 64'h0);
        step();
        check("bcast_noload", 64'(out_data[0]), 64'h12345678 & 64'h1);
        out_ready = 8'hFF;
        step();
        in_valid = 1'b0; in_bcast = 1'b0;
        step();
`endif

        // Randomized traffic honouring the hold rule while stalled.
        for (int k = 0; k < 3000; k++) begin
            bit hold;
            hold = in_valid && !in_ready;
            out_ready = 8'($urandom);
            if (!hold) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_sel   = 3'($urandom);
                in_data  = $urandom;
`ifdef DEMUX8_BROADCAST_EN
                in_bcast = ($urandom_range(0, 9) == 0);
`endif
            end
            step();
        end
        in_valid = 1'b0; out_ready = 8'h00;
`ifdef DEMUX8_BROADCAST_EN
        in_bcast = 1'b0;
`endif
        step();

        // Fill slots 2 and 5, then reset asynchronously between edges.
        in_valid = 1'b1; in_sel = 3'd2; in_data = 32'h22;
        step();
        in_sel = 3'd5; in_data = 32'h55;
        step();
        in_valid = 1'b0;
        check("pre_reset_valid", 64'(out_valid & 8'h24), 64'h24);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'h0);
        check("midrst_out_data", 64'(|out_data), 64'h0);
        check("midrst_stall", 64'(stall_count), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
